// File: rtl/wb_retire_monitor.sv
// Writeback retirement monitor: retired/cycle counters, same-PC halt detection and a register-write trace FIFO.
// Optional build macro WB_MON_ZERO_FILTER_EN keeps writes to register 0 out of the trace.
module wb_retire_monitor #(
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32,
    parameter int HALT_REPEAT = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WB_Valid,
    input  logic [31:0]      WB_PC,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_WriteReg,
    input  logic [31:0]      WB_WriteData,
    input  logic             Trace_Ready,
    output logic             Trace_Valid,
    output logic [31:0]      Trace_PC,
    output logic [4:0]       Trace_Reg,
    output logic [31:0]      Trace_Data,
    output logic             Trace_Overflow,
    output logic [CNT_W-1:0] Retired,
    output logic [CNT_W-1:0] Cycles,
    output logic             Halted
);

    localparam int PTR_W  = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int OCC_W  = $clog2(TRACE_DEPTH + 1);
    localparam int SAME_W = $clog2(HALT_REPEAT + 1);
    localparam int ENT_W  = 32 + 5 + 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [ENT_W-1:0]  mem [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [OCC_W-1:0]  occ, occ_next, remain;
    logic [31:0]       last_pc;
    logic              last_valid;
    logic [SAME_W-1:0] same_cnt, same_next;

    logic act, push, pop, full, wr_en, drop;
    logic [ENT_W-1:0] push_ent, head_next;

    always_comb begin
        act = WB_Valid & ~Halted;
`ifdef WB_MON_ZERO_FILTER_EN
        push = act & WB_RegWrite & (WB_WriteReg != 5'd0);
`else
        push = act & WB_RegWrite;
`endif
        push_ent = {WB_PC, WB_WriteReg, WB_WriteData};
        full     = (occ == OCC_W'(TRACE_DEPTH));
        pop      = Trace_Valid & Trace_Ready;
        // A full FIFO still accepts a push when the head leaves at the same edge.
        wr_en    = push & (~full | pop);
        drop     = push & full & ~pop;
        occ_next = occ + OCC_W'(wr_en) - OCC_W'(pop);
        remain   = occ - OCC_W'(pop);
        rd_next  = rd_ptr + PTR_W'(pop);

        // Head register is preloaded so the outputs stay registered with no fall-through.
        head_next = '0;
        if (occ_next != '0) begin
            if (remain == '0)
                head_next = push_ent;
            else
                head_next = mem[rd_next];
        end

        same_next = (last_valid && WB_PC == last_pc) ? same_cnt + SAME_W'(1) : SAME_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            Trace_Valid    <= 1'b0;
            Trace_PC       <= '0;
            Trace_Reg      <= '0;
            Trace_Data     <= '0;
            Trace_Overflow <= 1'b0;
            Retired        <= '0;
            Cycles         <= '0;
            Halted         <= 1'b0;
            last_pc        <= '0;
            last_valid     <= 1'b0;
            same_cnt       <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr      <= rd_next;
            occ         <= occ_next;
            Trace_Valid <= (occ_next != '0);
            {Trace_PC, Trace_Reg, Trace_Data} <= head_next;
            if (drop)
                Trace_Overflow <= 1'b1;
            if (!Halted)
                Cycles <= sat_inc(Cycles);
            if (act) begin
                Retired    <= sat_inc(Retired);
                last_pc    <= WB_PC;
                last_valid <= 1'b1;
                same_cnt   <= same_next;
                if (same_next == SAME_W'(HALT_REPEAT))
                    Halted <= 1'b1;
            end
        end
    end

endmodule
